// File: rtl/vga_ctrl.sv
// VGA timing generator: free-running pixel/line counters, combinational memory address,
// and registered sync, blank and colour outputs that stay mutually aligned.
module vga_ctrl #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] vga_data,
  output logic [9:0]  h_addr,
  output logic [9:0]  v_addr,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
);

  localparam int unsigned HTotal = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned VTotal = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  // Totals are limited to 1023, so every boundary fits the 10-bit counters.
  localparam logic [9:0] HMax    = 10'(HTotal - 1);
  localparam logic [9:0] VMax    = 10'(VTotal - 1);
  localparam logic [9:0] HSyncW  = 10'(H_SYNC);
  localparam logic [9:0] VSyncW  = 10'(V_SYNC);
  localparam logic [9:0] HStart  = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] HEnd    = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] VStart  = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] VEnd    = 10'(V_SYNC + V_BACK + V_ACTIVE);

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       h_act, v_act, act;

  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == HMax) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == VMax) ? '0 : vcnt_q + 10'd1;
    end
  end

  always_comb begin
    h_act  = (hcnt_q >= HStart) && (hcnt_q < HEnd);
    v_act  = (vcnt_q >= VStart) && (vcnt_q < VEnd);
    act    = h_act && v_act;
    h_addr = act ? hcnt_q - HStart : '0;
    v_addr = act ? vcnt_q - VStart : '0;
  end

  // Outputs describe the cycle that just ended, giving one clock of address-to-colour latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_q                <= '0;
      vcnt_q                <= '0;
      hsync                 <= 1'b0;
      vsync                 <= 1'b0;
      blank_n               <= 1'b0;
      {vga_r, vga_g, vga_b} <= '0;
      frame_start           <= 1'b0;
    end else begin
      hcnt_q                <= hcnt_d;
      vcnt_q                <= vcnt_d;
      hsync                 <= (hcnt_q >= HSyncW);
      vsync                 <= (vcnt_q >= VSyncW);
      blank_n               <= act;
      {vga_r, vga_g, vga_b} <= act ? vga_data : 24'h0;
      frame_start           <= (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
    end
  end

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: small-timing instance checked every cycle against a position-based model,
// plus a vector table, timing measurements, wrap, mid-frame reset and a 1023-wide line instance.
module tb_vga_ctrl;

  localparam int HS = 4, HB = 3, HA = 10, HF = 2;
  localparam int VS = 2, VB = 2, VA = 5, VF = 1;
  localparam int HT = HS + HB + HA + HF;  // 19
  localparam int VT = VS + VB + VA + VF;  // 10
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [23:0] rnd_data, vga_data;
  logic [9:0]  h_addr, v_addr;
  logic        hsync, vsync, blank_n, frame_start;
  logic [7:0]  vga_r, vga_g, vga_b;

  logic [9:0]  w_h_addr, w_v_addr;
  logic        w_hsync, w_vsync, w_blank_n, w_frame_start;
  logic [7:0]  w_r, w_g, w_b;

  always #5 clk = ~clk;

  assign vga_data = (mode == 2'd1) ? {h_addr[7:0], v_addr[7:0], 8'hA5} :
                    (mode == 2'd2) ? 24'hFFFFFF : rnd_data;

  vga_ctrl #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
  ) u_dut (
    .clk(clk), .rst(rst), .vga_data(vga_data), .h_addr(h_addr), .v_addr(v_addr),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .vga_r(vga_r), .vga_g(vga_g),
    .vga_b(vga_b), .frame_start(frame_start)
  );

  // Line total of exactly 1023 exercises the top of the 10-bit counter range.
  vga_ctrl #(
    .H_SYNC(100), .H_BACK(100), .H_ACTIVE(800), .H_FRONT(23),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(2), .V_FRONT(1)
  ) u_wide (
    .clk(clk), .rst(rst), .vga_data(24'h123456), .h_addr(w_h_addr), .v_addr(w_v_addr),
    .hsync(w_hsync), .vsync(w_vsync), .blank_n(w_blank_n), .vga_r(w_r), .vga_g(w_g),
    .vga_b(w_b), .frame_start(w_frame_start)
  );

  int          tests = 0;
  int          fails = 0;
  int          pos;       // rising edges since reset release
  logic [23:0] prev_in;   // expected pixel data presented during cycle pos

  typedef struct {
    int         pos;
    logic       hs, vs, bl, fs;
    logic [9:0] ha, va;
  } vec_t;

  vec_t tv[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (pos %0d)", name, act, exp, pos);
    end
  endtask

  function automatic bit h_in(input int hc);
    return hc >= HS + HB && hc < HS + HB + HA;
  endfunction

  function automatic bit v_in(input int vc);
    return vc >= VS + VB && vc < VS + VB + VA;
  endfunction

  task automatic set_input();
    int hc, vc;
    logic [9:0] ha, va;
    hc = pos % HT;
    vc = (pos / HT) % VT;
    ha = (h_in(hc) && v_in(vc)) ? 10'(hc - (HS + HB)) : 10'd0;
    va = (h_in(hc) && v_in(vc)) ? 10'(vc - (VS + VB)) : 10'd0;
    rnd_data = 24'($urandom);
    case (mode)
      2'd1:    prev_in = {ha[7:0], va[7:0], 8'hA5};
      2'd2:    prev_in = 24'hFFFFFF;
      default: prev_in = rnd_data;
    endcase
  endtask

  task automatic step();
    int  p, phc, pvc, chc, cvc;
    bit  pa, ca;
    @(posedge clk);
    #1;
    pos++;
    p   = pos - 1;
    phc = p % HT;
    pvc = (p / HT) % VT;
    pa  = h_in(phc) && v_in(pvc);
    chc = pos % HT;
    cvc = (pos / HT) % VT;
    ca  = h_in(chc) && v_in(cvc);
    check("hsync", 32'(hsync), 32'(phc >= HS));
    check("vsync", 32'(vsync), 32'(pvc >= VS));
    check("blank_n", 32'(blank_n), 32'(pa));
    check("colour", 32'({vga_r, vga_g, vga_b}), pa ? 32'(prev_in) : 32'd0);
    check("frame_start", 32'(frame_start), 32'(phc == 0 && pvc == 0));
    check("h_addr", 32'(h_addr), ca ? 32'(chc - (HS + HB)) : 32'd0);
    check("v_addr", 32'(v_addr), ca ? 32'(cvc - (VS + VB)) : 32'd0);
    set_input();
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return hsync;
      1:       return vsync;
      2:       return ~blank_n;
      default: return ~frame_start;
    endcase
  endfunction

  // Finds a falling edge of the selected signal, then its low length and falling-to-falling period.
  task automatic measure(input int which, output int low_len, output int period);
    logic last;
    int   n;
    low_len = -1;
    period  = -1;
    n = 0;
    do begin last = sig(which); step(); n++; end
    while (!(last && !sig(which)) && n < 3 * FT);
    if (!(last && !sig(which))) return;
    n = 0;
    while (!sig(which) && n < 3 * FT) begin step(); n++; end
    low_len = n;
    n = 0;
    do begin last = sig(which); step(); n++; end
    while (!(last && !sig(which)) && n < 3 * FT);
    period = (last && !sig(which)) ? low_len + n : -1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_hsync"}, 32'(hsync), 32'd0);
    check({tag, "_vsync"}, 32'(vsync), 32'd0);
    check({tag, "_blank_n"}, 32'(blank_n), 32'd0);
    check({tag, "_colour"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_h_addr"}, 32'(h_addr), 32'd0);
    check({tag, "_v_addr"}, 32'(v_addr), 32'd0);
  endtask

  initial begin
    int lo, per, n, w_falls, w_t0, w_per, w_run, w_maxrun, w_bad;
    logic w_last;
    logic [9:0] w_max;

    tv[0]  = '{1,   1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0};
    tv[1]  = '{2,   1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
    tv[2]  = '{5,   1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
    tv[3]  = '{38,  1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
    tv[4]  = '{39,  1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0};
    tv[5]  = '{83,  1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0};
    tv[6]  = '{84,  1'b1, 1'b1, 1'b1, 1'b0, 10'd1, 10'd0};
    tv[7]  = '{93,  1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0};
    tv[8]  = '{94,  1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0};
    tv[9]  = '{168, 1'b1, 1'b1, 1'b1, 1'b0, 10'd9, 10'd4};
    tv[10] = '{181, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0};
    tv[11] = '{190, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0};
    tv[12] = '{191, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0};

    rst      = 1'b0;
    mode     = 2'd0;
    rnd_data = 24'h0;
    pos      = 0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    pos = 0;
    set_input();

    for (int i = 0; i < 13; i++) begin
      while (pos < tv[i].pos) step();
      check($sformatf("vec%0d_hsync", i), 32'(hsync), 32'(tv[i].hs));
      check($sformatf("vec%0d_vsync", i), 32'(vsync), 32'(tv[i].vs));
      check($sformatf("vec%0d_blank_n", i), 32'(blank_n), 32'(tv[i].bl));
      check($sformatf("vec%0d_frame_start", i), 32'(frame_start), 32'(tv[i].fs));
      check($sformatf("vec%0d_h_addr", i), 32'(h_addr), 32'(tv[i].ha));
      check($sformatf("vec%0d_v_addr", i), 32'(v_addr), 32'(tv[i].va));
    end

    // Address-tagged pixels, then constant white, each over a full frame.
    mode = 2'd1;
    set_input();
    repeat (FT) step();
    mode = 2'd2;
    set_input();
    repeat (FT) step();
    mode = 2'd0;
    set_input();

    measure(0, lo, per);
    check("hsync_low_len", 32'(lo), 32'(HS));
    check("hsync_period", 32'(per), 32'(HT));
    measure(2, lo, per);
    check("blank_high_len", 32'(lo), 32'(HA));
    measure(1, lo, per);
    check("vsync_low_len", 32'(lo), 32'(VS * HT));
    check("vsync_period", 32'(per), 32'(FT));
    measure(3, lo, per);
    check("frame_start_width", 32'(lo), 32'd1);
    check("frame_start_period", 32'(per), 32'(FT));

    // Last cycle of the frame, then the wrap and the frame_start one clock later.
    while (pos % FT != FT - 1) step();
    check("wrap_pre_fs", 32'(frame_start), 32'd0);
    step();
    check("wrap_zero_fs", 32'(frame_start), 32'd0);
    check("wrap_zero_h_addr", 32'(h_addr), 32'd0);
    step();
    check("wrap_fs", 32'(frame_start), 32'd1);

    // Abort mid-frame inside the visible area, between clock edges.
    while (pos % FT != 6 * HT + 10) step();
    check("pre_reset_blank_n", 32'(blank_n), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    check_zero("midreset");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_zero("held_reset");
    end
    @(negedge clk);
    rst = 1'b1;
    pos = 0;
    set_input();
    step();
    check("post_reset_fs", 32'(frame_start), 32'd1);
    check("post_reset_hsync", 32'(hsync), 32'd0);
    check("post_reset_vsync", 32'(vsync), 32'd0);
    measure(3, lo, per);
    check("post_reset_frame_period", 32'(per), 32'(FT));

    // Wide-line instance: line period 1023, 800 visible pixels, top address 799.
    w_falls  = 0; w_t0 = 0; w_per = -1; w_run = 0; w_maxrun = 0; w_bad = 0;
    w_max    = 10'd0;
    w_last   = w_hsync;
    n        = 0;
    while (n < 6000) begin
      step();
      n++;
      if (w_last && !w_hsync) begin
        if (w_falls == 1) w_per = n - w_t0;
        w_t0 = n;
        w_falls++;
      end
      w_last = w_hsync;
      if (w_h_addr > w_max) w_max = w_h_addr;
      w_run = w_blank_n ? w_run + 1 : 0;
      if (w_run > w_maxrun) w_maxrun = w_run;
      if (w_blank_n && {w_r, w_g, w_b} != 24'h123456) w_bad++;
      if (!w_blank_n && {w_r, w_g, w_b} != 24'h0) w_bad++;
    end
    check("wide_hsync_period", 32'(w_per), 32'd1023);
    check("wide_h_addr_max", 32'(w_max), 32'd799);
    check("wide_blank_run", 32'(w_maxrun), 32'd800);
    check("wide_colour_errors", 32'(w_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_ctrl.md
VGA_CTRL -- requirements
Module: vga_ctrl

Interface
REQ-001 SHALL have parameter H_SYNC, default 96: hsync low width, pixel clocks.
REQ-002 SHALL have parameter H_BACK, default 48: horizontal back porch, pixel clocks.
REQ-003 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-004 SHALL have parameter H_FRONT, default 16: horizontal front porch, pixel clocks.
REQ-005 SHALL have parameter V_SYNC, default 2: vsync low width, lines.
REQ-006 SHALL have parameter V_BACK, default 33: vertical back porch, lines.
REQ-007 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-008 SHALL have parameter V_FRONT, default 10: vertical front porch, lines.
REQ-009 SHALL have port clk  input  1  pixel clock; all state on rising edge.
REQ-010 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-011 SHALL have port vga_data  input  24  pixel from video memory, {R,G,B}, valid combinationally for the current h_addr/v_addr.
REQ-012 SHALL have port h_addr  output  10  pixel column requested from video memory.
REQ-013 SHALL have port v_addr  output  10  pixel row requested from video memory.
REQ-014 SHALL have port hsync  output  1  horizontal sync, active low.
REQ-015 SHALL have port vsync  output  1  vertical sync, active low.
REQ-016 SHALL have port blank_n  output  1  high while the output pixel is visible.
REQ-017 SHALL have port vga_r, vga_g, vga_b  output  8 each  registered pixel colour.
REQ-018 SHALL have port frame_start  output  1  one-cycle pulse on the first output cycle of each frame.

Function
REQ-019 SHALL keep hcnt in 0..H_TOTAL-1, H_TOTAL = sum of the H parameters (800 default), incrementing every clock and wrapping to 0.
REQ-020 SHALL keep vcnt in 0..V_TOTAL-1 (525 default), incrementing only on the hcnt wrap and wrapping to 0 after V_TOTAL-1; a simultaneous hcnt and vcnt wrap returns both to 0.
REQ-021 SHALL order each line as sync, back porch, active, front porch; the active region is hcnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1] (144..783 default).
REQ-022 SHALL order each frame the same way; the active region is vcnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE-1] (35..514 default).
REQ-023 SHALL drive h_addr = hcnt-(H_SYNC+H_BACK) and v_addr = vcnt-(V_SYNC+V_BACK) combinationally from the counters when both counters are active, else 0.
REQ-024 SHALL register, on each edge, the state of the cycle just ended: hsync=(hcnt>=H_SYNC), vsync=(vcnt>=V_SYNC), blank_n=(h active AND v active).
REQ-025 SHALL register {vga_r,vga_g,vga_b}=vga_data when that cycle was active, else 0.
REQ-026 SHALL have a latency of 1 clock from address to colour; sync, blank_n and colour stay mutually aligned.
REQ-027 SHALL register frame_start=1 exactly when the cycle just ended had hcnt=0 and vcnt=0.
REQ-028 SHALL leave arithmetic unsigned; a parameterised total up to 1023 SHALL fit the 10-bit counters without overflow.

Reset
REQ-029 SHALL, while rst=0, asynchronously force hcnt=0, vcnt=0, hsync=0, vsync=0, blank_n=0, colour=0 and frame_start=0; h_addr and v_addr read 0.
REQ-030 SHALL treat assertion mid-frame as an immediate abort, with no completion of the line.
REQ-031 SHALL, on the first edge after deassertion, register the state for hcnt=0/vcnt=0: frame_start=1, hsync=0, vsync=0.

Verification
REQ-032 SHALL cover line timing: free-run 3 lines -> hsync period 800 clocks, low 96 clocks; blank_n high 640 consecutive clocks per visible line.
REQ-033 SHALL cover frame timing: free-run 2 frames -> vsync low 1600 clocks, frame period 420000 clocks, frame_start pulses exactly 420000 apart.
REQ-034 SHALL cover address and data alignment: drive vga_data={h_addr[7:0],v_addr[7:0],8'hA5} -> output pixel k of row j is {k[7:0],j[7:0],A5} one clock after its address, starting hcnt=144, vcnt=35.
REQ-035 SHALL cover blanking: vga_data=24'hFFFFFF constantly -> colour 0 whenever blank_n=0; h_addr=v_addr=0 outside active.
REQ-036 SHALL cover wrap: observe hcnt=799, vcnt=524 -> next cycle both 0, then frame_start=1 one clock later.
REQ-037 SHALL cover reset mid-frame: assert rst at vcnt=200, hcnt=400 between clock edges -> all outputs 0 immediately; after release, frame_start on first edge, full frame timing resumes.
